amm_read_master: RTL
====================

// Module: amm_read_master
// PURPOSE
//  Avalon-MM read initiator that feeds the ALU operand path from the memory-mapped register file.
//  - A client issues a command: base address and beat count.
//  - The block performs that many sequential single-beat AMM reads.
//  - Each read holds amm_read/amm_address stable until waitrequest drops.
//  - Each beat's data and response are returned on a one-cycle response strobe.
//  - A watchdog aborts the command if the slave stalls too long.
// PARAMETERS
//  ADDR_W    8   AMM address width
//  DATA_W    8   AMM data width
//  LEN_W     4   width of cmd_len (max 15 beats per command)
//  TIMEOUT   16  max consecutive cycles with waitrequest high before abort
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       synchronous, active-low reset
//  cmd_valid        in   1       command request
//  cmd_ready        out  1       high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_addr         in   ADDR_W  first read address
//  cmd_len          in   LEN_W   number of beats (0 = no reads)
//  rsp_valid        out  1       one-cycle strobe per completed beat (no backpressure)
//  rsp_data         out  DATA_W  captured amm_readdata
//  rsp_resp         out  2       captured amm_response; 2'b10 = local timeout
//  rsp_last         out  1       with rsp_valid: final beat of the command
//  done             out  1       one-cycle pulse when the command finishes
//  amm_read         out  1       AMM read strobe (registered)
//  amm_address      out  ADDR_W  AMM address (registered)
//  amm_readdata     in   DATA_W  AMM read data
//  amm_waitrequest  in   1       AMM stall
//  amm_response     in   2       00 OK, 11 DECODE ERROR
// BEHAVIOUR
//  Reset values: all outputs 0 except cmd_ready=1. FSM goes to IDLE; counters are cleared.
//  Reset mid-command: amm_read is low the cycle after rst_n is sampled low, and the command is dropped silently.
//  FSM states: IDLE -> (READ <-> GAP) -> IDLE.
//   IDLE: accept latches addr, beats_left=cmd_len and clears the watchdog.
//     - len=0: done=1 next cycle, no AMM traffic, stay IDLE.
//     - len>0: go to READ and drive amm_read=1, amm_address=addr.
//   READ: amm_read/amm_address are held constant every cycle while waitrequest=1.
//     - On a posedge sampling waitrequest=0: capture readdata/response.
//     - Next cycle: rsp_valid=1 and amm_read=0.
//     - If beats_left==1: rsp_last=1, done=1, go to IDLE.
//     - Otherwise: decrement beats_left, addr=addr+1 (mod 2^ADDR_W; 0xFF wraps to 0x00), go to GAP.
//   GAP: exactly one cycle with amm_read=0 (the slave must see a fresh request), then READ.
//  Response handling:
//   - DECODE ERROR (11) is reported in rsp_resp and the burst continues.
//   - Data is passed through unmodified.
//  Watchdog:
//   - Counts READ cycles with waitrequest=1.
//   - Reaching TIMEOUT aborts next cycle: amm_read=0, rsp_valid=1, rsp_resp=2'b10, rsp_data=0, rsp_last=1, done=1, go to IDLE.
//   - Remaining beats are skipped.
//   - The watchdog clears at every new beat.
//  Latency:
//   - Against the register file (3 stall cycles), each beat takes 4 cycles with amm_read high plus 1 GAP cycle: 5 cycles/beat.
//   - rsp_valid follows the waitrequest=0 sample by 1 cycle.
//  cmd_valid outside IDLE is ignored (cmd_ready=0). A new command can be accepted the cycle after done.
//  No combinational path from AMM inputs to outputs.
// STRUCTURE
//  Shared include amm_defs.vh: ALU_AMM_ADDR_WITH, ALU_AMM_DATA_WITH, response codes AMM_RESP_OK=2'b00, AMM_RESP_SLVERR=2'b10, AMM_RESP_DECERR=2'b11.
//  FSM state encodings stay local to the module.
//  One sub-module, amm_watchdog:
//   - Parameter TIMEOUT.
//   - Inputs: clear, count_en.
//   - Output: expired.
// TESTING (bench uses the existing register-file slave unless noted)
//  1 addr=0x00 len=1 -> one rsp_valid, data=0x67(103), resp=00, rsp_last=1, done same cycle; amm_read high exactly 4 cycles
//  2 addr=0x0E len=3 -> data 227, 70, then resp=11 data=0 for 0x10; the 3rd beat has rsp_last; 3 AMM reads total
//  3 addr=0xFF len=2 -> data 245, then amm_address wraps to 0x00 -> data 103; GAP cycle between beats has amm_read=0
//  4 addr=0x30 len=0 -> done pulse one cycle after accept, no rsp_valid, amm_read never asserted
//  5 stub slave with waitrequest stuck high, len=4 -> after 16 stall cycles: resp=10, rsp_last=1, done=1, only 1 response
//  6 addr=0xA0 len=5, rst_n low during 2nd beat -> amm_read=0 next cycle, no done; new cmd addr=0xA0 len=1 -> data 2

Source files
------------

// File: rtl/amm_read_master_pkg.sv
// Shared definitions for the ALU operand-path Avalon-MM read initiator.
//   ALU_AMM_ADDR_WITH / ALU_AMM_DATA_WITH : default AMM address/data widths
//   AMM_RESP_*                            : Avalon-MM response codes
package amm_read_master_pkg;

    localparam int ALU_AMM_ADDR_WITH = 8;
    localparam int ALU_AMM_DATA_WITH = 8;

    localparam logic [1:0] AMM_RESP_OK     = 2'b00;
    // Also used for a local watchdog abort, since the slave never answered.
    localparam logic [1:0] AMM_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AMM_RESP_DECERR = 2'b11;

endpackage

// File: rtl/amm_watchdog.sv
// Stall watchdog for the AMM read initiator.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count (new command or new beat)
//   count_en   : one stalled cycle is being sampled this edge
//   expired    : this edge's sample is the TIMEOUT-th consecutive stall
module amm_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so a slave that never releases cannot wrap the count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (count_en && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the stall sample that brings the count to TIMEOUT, so the
    // abort becomes visible on the very next cycle.
    assign expired = count_en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/amm_read_master.sv
// Avalon-MM read initiator feeding the ALU operand path from the register file.
//   clk, rst_n       : clock, synchronous active-low reset
//   cmd_valid/ready  : command handshake (ready only while idle)
//   cmd_addr/len     : first address and beat count (0 = no reads)
//   rsp_valid/data/resp/last : one-cycle strobe per completed beat
//   done             : one-cycle pulse when the command finishes
//   amm_read/address : registered AMM request
//   amm_readdata/waitrequest/response : AMM slave returns
module amm_read_master
    import amm_read_master_pkg::*;
#(
    parameter int ADDR_W  = ALU_AMM_ADDR_WITH,
    parameter int DATA_W  = ALU_AMM_DATA_WITH,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic              rsp_last,
    output logic              done,
    output logic              amm_read,
    output logic [ADDR_W-1:0] amm_address,
    input  logic [DATA_W-1:0] amm_readdata,
    input  logic              amm_waitrequest,
    input  logic [1:0]        amm_response
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_GAP
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [LEN_W-1:0]  beats_left, beats_next;
    logic              amm_read_next;
    logic [ADDR_W-1:0] amm_address_next;
    logic              rsp_valid_next;
    logic [DATA_W-1:0] rsp_data_next;
    logic [1:0]        rsp_resp_next;
    logic              rsp_last_next;
    logic              done_next;
    logic              wd_clear, wd_count_en, wd_expired;

    assign cmd_ready = (state == ST_IDLE);

    // The watchdog only runs while a request is outstanding; both IDLE
    // (accept) and GAP (start of the next beat) restart it.
    assign wd_clear    = (state != ST_READ);
    assign wd_count_en = (state == ST_READ) && amm_waitrequest;

    amm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    // Every output is computed here and registered below, so no AMM input
    // reaches an output combinationally.
    always_comb begin
        state_next       = state;
        addr_next        = addr_q;
        beats_next       = beats_left;
        amm_read_next    = amm_read;
        amm_address_next = amm_address;
        rsp_valid_next   = 1'b0;
        rsp_data_next    = rsp_data;
        rsp_resp_next    = rsp_resp;
        rsp_last_next    = 1'b0;
        done_next        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    beats_next = cmd_len;
                    if (cmd_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        amm_read_next    = 1'b1;
                        amm_address_next = cmd_addr;
                        state_next       = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (!amm_waitrequest) begin
                    amm_read_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = amm_readdata;
                    rsp_resp_next  = amm_response;
                    if (beats_left == LEN_W'(1)) begin
                        rsp_last_next = 1'b1;
                        done_next     = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        beats_next = beats_left - LEN_W'(1);
                        addr_next  = addr_q + ADDR_W'(1);
                        state_next = ST_GAP;
                    end
                end else if (wd_expired) begin
                    // Abort the whole command; remaining beats are dropped.
                    amm_read_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = '0;
                    rsp_resp_next  = AMM_RESP_SLVERR;
                    rsp_last_next  = 1'b1;
                    done_next      = 1'b1;
                    state_next     = ST_IDLE;
                end
            end

            ST_GAP: begin
                // One idle cycle so the slave sees a fresh request per beat.
                amm_read_next    = 1'b1;
                amm_address_next = addr_q;
                state_next       = ST_READ;
            end

            default: begin
                amm_read_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            beats_left  <= '0;
            amm_read    <= 1'b0;
            amm_address <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= AMM_RESP_OK;
            rsp_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            addr_q      <= addr_next;
            beats_left  <= beats_next;
            amm_read    <= amm_read_next;
            amm_address <= amm_address_next;
            rsp_valid   <= rsp_valid_next;
            rsp_data    <= rsp_data_next;
            rsp_resp    <= rsp_resp_next;
            rsp_last    <= rsp_last_next;
            done        <= done_next;
        end
    end

endmodule
